shield_damage_map: RTL

- Consumer end of the shield collision path.
- Takes the shield bitmap drawing request, a shot drawing request and the pixel offset inside the shield; detects shot/shield overlap and emits the collision pulse.
- Keeps a per-cell damage map and masks the shield drawing request so that destroyed cells disappear.
- One instance per shield, between the shield bitmap and the video mux / collision logic.

---
 rtl/shield_damage_map.sv | 138 +++++++++++++
 1 files changed

// File: rtl/shield_damage_map.sv
// Per-shield damage map: masks destroyed 8x8 cells and emits one collision pulse per frame.
// Optional: define SHIELD_HIT_COUNT_EN to add the hitCount output (applied hits, saturating).
module shield_damage_map #(
  parameter int CELL_COLS       = 8,
  parameter int CELL_ROWS       = 4,
  parameter int CELL_SHIFT      = 3,
  parameter int HITS_TO_DESTROY = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               playGame,
  input  logic signed [10:0] offsetX,
  input  logic signed [10:0] offsetY,
  input  logic               shieldRawDR,
  input  logic               shotDR,
  output logic               drawingRequest,
  output logic               collision,
  output logic               shieldDestroyed,
`ifdef SHIELD_HIT_COUNT_EN
  output logic [7:0]         hitCount,
`endif
  output logic [1:0]         dbgState
);

  localparam int NCELLS = CELL_COLS * CELL_ROWS;
  localparam int IDXW   = (NCELLS > 1) ? $clog2(NCELLS) : 1;
  localparam logic signed [10:0] X_LIM = 11'(CELL_COLS << CELL_SHIFT);
  localparam logic signed [10:0] Y_LIM = 11'(CELL_ROWS << CELL_SHIFT);
  localparam logic [1:0] HMAX = 2'(HITS_TO_DESTROY);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ARMED       = 2'd1,
    HIT_LATCHED = 2'd2,
    APPLY       = 2'd3
  } state_t;

  state_t          state, state_n;
  logic [1:0]      damage [NCELLS];
  logic [IDXW-1:0] latched, latched_n, cell_idx;
  logic [10:0]     col, row;
  logic [1:0]      cell_dmg;
  logic            in_range, overlap, clear_map, apply_hit, coll_n, all_sat;

  always_comb begin
    in_range = (offsetX >= 11'sd0) && (offsetY >= 11'sd0) &&
               (offsetX < X_LIM) && (offsetY < Y_LIM);
    col      = $unsigned(offsetX) >> CELL_SHIFT;
    row      = $unsigned(offsetY) >> CELL_SHIFT;
    cell_idx = IDXW'(int'(row) * CELL_COLS + int'(col));
    // Out-of-range pixels read as saturated so they never draw or collide.
    cell_dmg       = in_range ? damage[cell_idx] : HMAX;
    drawingRequest = shieldRawDR && in_range && (cell_dmg < HMAX);
    overlap        = drawingRequest && shotDR;
  end

  always_comb begin
    all_sat = 1'b1;
    for (int i = 0; i < NCELLS; i++) begin
      if (damage[i] != HMAX) all_sat = 1'b0;
    end
    shieldDestroyed = all_sat;
  end

  always_comb begin
    state_n   = state;
    latched_n = latched;
    coll_n    = 1'b0;
    clear_map = 1'b0;
    apply_hit = 1'b0;
    case (state)
      IDLE: begin
        clear_map = 1'b1;
        if (playGame) state_n = ARMED;
      end
      ARMED: begin
        if (overlap) begin
          latched_n = cell_idx;
          coll_n    = 1'b1;
          state_n   = HIT_LATCHED;
        end
      end
      HIT_LATCHED: begin
        if (startOfFrame) state_n = APPLY;
      end
      APPLY: begin
        apply_hit = 1'b1;
        state_n   = ARMED;
      end
      default: state_n = IDLE;
    endcase
    // Leaving the game wins over everything, including a pending apply.
    if (!playGame) begin
      state_n   = IDLE;
      coll_n    = 1'b0;
      clear_map = 1'b1;
      apply_hit = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      collision <= 1'b0;
      latched   <= '0;
    end else begin
      state     <= state_n;
      collision <= coll_n;
      latched   <= latched_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCELLS; i++) damage[i] <= 2'd0;
    end else if (clear_map) begin
      for (int i = 0; i < NCELLS; i++) damage[i] <= 2'd0;
    end else if (apply_hit && (damage[latched] != HMAX)) begin
      damage[latched] <= damage[latched] + 2'd1;
    end
  end

`ifdef SHIELD_HIT_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hitCount <= 8'd0;
    end else if (clear_map) begin
      hitCount <= 8'd0;
    end else if (apply_hit && (damage[latched] != HMAX) && (hitCount != 8'hFF)) begin
      hitCount <= hitCount + 8'd1;
    end
  end
`endif

  assign dbgState = state;

endmodule
